// File: rtl/seq_mul_hs_pkg.sv
// seq_mul_hs_pkg: shared FSM state encoding for the handshaked sequential multiplier
package seq_mul_hs_pkg;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_CALC = 3'd1;
   localparam logic [2:0] ST_WREL = 3'd2;
   localparam logic [2:0] ST_OUT  = 3'd3;
   localparam logic [2:0] ST_ACK  = 3'd4;
   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      CALC = ST_CALC,
      WREL = ST_WREL,
      OUT  = ST_OUT,
      ACK  = ST_ACK
   } state_t;
endpackage

// File: rtl/seq_mul_hs_mag_conv.sv
// mag_conv: conditional two's-complement negate, used for operand abs and product sign fix-up
module mag_conv #(
   parameter int W = 8
) (
   input  logic [W-1:0] i_a,
   input  logic         i_neg,
   output logic [W-1:0] o_y
);
   // negate when requested; negating zero yields zero, so a zero product never turns negative
   always_comb o_y = i_neg ? (~i_a) + W'(1) : i_a;
endmodule

// File: rtl/seq_mul_hs.sv
// seq_mul_hs: two-producer/one-consumer handshaked shift-add multiplier, signed or unsigned
module seq_mul_hs
   import seq_mul_hs_pkg::*;
#(
   parameter int N = 8
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [N-1:0]   x,
   input  logic           dav1_,
   output logic           rfd1,
   input  logic [N-1:0]   y,
   input  logic           dav2_,
   output logic           rfd2,
   input  logic           sgn,
   output logic [2*N-1:0] m,
   output logic           dav_out_,
   input  logic           rfd_out,
   output logic           busy
);
   localparam int CW = $clog2(N) + 1;
   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [2*N-1:0]   r_a;
   logic [N-1:0]     r_b;
   logic [2*N-1:0]   r_acc;
   logic [2*N-1:0]   r_m;
   logic             r_neg;
   logic             r_rfd;
   logic             r_dav;
   logic             r_busy;
   logic [N-1:0]     w_ax;
   logic [N-1:0]     w_ay;
   logic [2*N-1:0]   w_p;
   mag_conv #(.W(N)) u_ax (.i_a(x), .i_neg(sgn & x[N-1]), .o_y(w_ax));
   mag_conv #(.W(N)) u_ay (.i_a(y), .i_neg(sgn & y[N-1]), .o_y(w_ay));
   mag_conv #(.W(2*N)) u_p (.i_a(r_acc), .i_neg(r_neg), .o_y(w_p));
   assign rfd1     = r_rfd;
   assign rfd2     = r_rfd;
   assign m        = r_m;
   assign dav_out_ = r_dav;
   assign busy     = r_busy;
   // handshake FSM and shift-add datapath; magnitudes are taken at capture so later input changes are ignored
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_m     <= '0;
         r_neg   <= 1'b0;
         r_rfd   <= 1'b1;
         r_dav   <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (!dav1_ && !dav2_) begin
               r_a     <= {{N{1'b0}}, w_ax};
               r_b     <= w_ay;
               r_acc   <= '0;
               r_neg   <= sgn & (x[N-1] ^ y[N-1]);
               r_cnt   <= '0;
               r_rfd   <= 1'b0;
               r_busy  <= 1'b1;
               r_state <= CALC;
            end
            CALC: begin
               r_acc   <= r_b[0] ? r_acc + r_a : r_acc;
               r_a     <= r_a << 1;
               r_b     <= r_b >> 1;
               r_cnt   <= (r_cnt == CW'(N-1)) ? '0 : r_cnt + CW'(1);
               r_state <= (r_cnt == CW'(N-1)) ? WREL : CALC;
            end
            WREL: if (dav1_ && dav2_) begin
               r_m     <= w_p;
               r_dav   <= 1'b0;
               r_state <= OUT;
            end
            OUT: if (!rfd_out) begin
               r_dav   <= 1'b1;
               r_state <= ACK;
            end
            ACK: if (rfd_out) begin
               r_rfd   <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_mul_hs.sv
// tb_seq_mul_hs: randomized scoreboard bench for seq_mul_hs against an arithmetic reference
module tb_seq_mul_hs;
   localparam int N = 8;
   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   x = '0;
   logic [N-1:0]   y = '0;
   logic           dav1_ = 1'b1;
   logic           dav2_ = 1'b1;
   logic           sgn = 1'b0;
   logic           rfd_out = 1'b1;
   logic           rfd1, rfd2, dav_out_, busy;
   logic [2*N-1:0] m;
   int             n_chk = 0;
   int             n_fail = 0;
   logic [2*N-1:0] exp_q[$];
   logic [2*N-1:0] prev_m;
   logic           prev_dav, prev_rst;
   seq_mul_hs #(.N(N)) dut (
      .clock(clock), .reset(reset), .x(x), .dav1_(dav1_), .rfd1(rfd1),
      .y(y), .dav2_(dav2_), .rfd2(rfd2), .sgn(sgn), .m(m),
      .dav_out_(dav_out_), .rfd_out(rfd_out), .busy(busy)
   );
   always #5 clock = ~clock;
   function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
      longint pa, pb;
      pa = s ? longint'($signed(a)) : longint'(a);
      pb = s ? longint'($signed(b)) : longint'(b);
      return (2*N)'(pa * pb);
   endfunction
   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask
   // monitor: product checked against the scoreboard when dav_out_ falls; m must otherwise hold
   always @(negedge clock) begin
      if (prev_rst === 1'b0 || prev_rst === 1'b1) begin
         chk("rfd_equal", longint'(rfd1), longint'(rfd2));
         if (prev_rst) chk("m_reset", longint'(m), 0);
         else if (prev_dav && !dav_out_) begin
            if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
            else chk("product", longint'(m), longint'(exp_q.pop_front()));
         end else chk("m_hold", longint'(m), longint'(prev_m));
      end
      prev_m   = m;
      prev_dav = dav_out_;
      prev_rst = reset;
   end
   task automatic do_txn(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                         input int hold, input int pre, input int owait);
      int lat;
      logic [2*N-1:0] mh;
      @(negedge clock);
      chk("idle_busy", longint'(busy), 0);
      chk("idle_rfd", longint'(rfd1), 1);
      x = a; y = b; sgn = s;
      dav1_ = 1'b0;
      for (int i = 0; i < pre; i++) begin
         @(negedge clock);
         chk("nocap_busy", longint'(busy), 0);
         chk("nocap_rfd", longint'(rfd2), 1);
      end
      dav2_ = 1'b0;
      exp_q.push_back(model(a, b, s));
      @(negedge clock);
      chk("cap_busy", longint'(busy), 1);
      chk("cap_rfd", longint'(rfd1), 0);
      x = N'($urandom); y = N'($urandom); sgn = 1'($urandom);
      lat = 0;
      while (dav_out_ && lat < 200) begin
         if (lat >= hold) begin dav1_ = 1'b1; dav2_ = 1'b1; end
         @(negedge clock);
         lat++;
      end
      dav1_ = 1'b1; dav2_ = 1'b1;
      chk("latency", longint'(lat), longint'((hold + 1 > N + 1) ? hold + 1 : N + 1));
      mh = m;
      for (int i = 0; i < owait; i++) begin
         @(negedge clock);
         chk("out_dav", longint'(dav_out_), 0);
         chk("out_m", longint'(m), longint'(mh));
      end
      rfd_out = 1'b0;
      @(negedge clock);
      chk("ack_dav", longint'(dav_out_), 1);
      chk("ack_busy", longint'(busy), 1);
      rfd_out = 1'b1;
      @(negedge clock);
      chk("back_idle_busy", longint'(busy), 0);
      chk("back_idle_rfd", longint'(rfd1), 1);
   endtask
   initial begin
      repeat (3) @(negedge clock);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_m", longint'(m), 0);
      chk("rst_dav", longint'(dav_out_), 1);
      chk("rst_rfd", longint'(rfd1), 1);
      reset = 1'b0;
      do_txn(8'hFF, 8'hFF, 1'b0, 0, 0, 0);
      do_txn(8'h80, 8'h80, 1'b1, 0, 0, 1);
      do_txn(8'hFF, 8'h7F, 1'b1, 2, 0, 0);
      do_txn(8'h00, 8'h80, 1'b1, 0, 0, 0);
      do_txn(8'h5A, 8'hC3, 1'b0, 0, 20, 0);
      do_txn(8'h81, 8'h7F, 1'b1, 30, 0, 0);
      do_txn(8'hA7, 8'h3C, 1'b1, 0, 0, 10);
      @(negedge clock);
      x = N'($urandom); y = N'($urandom); sgn = 1'b0;
      dav1_ = 1'b0; dav2_ = 1'b0;
      repeat (5) @(negedge clock);
      chk("midcalc_busy", longint'(busy), 1);
      dav1_ = 1'b1; dav2_ = 1'b1;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("abort_busy", longint'(busy), 0);
      chk("abort_m", longint'(m), 0);
      chk("abort_dav", longint'(dav_out_), 1);
      chk("abort_rfd", longint'(rfd2), 1);
      do_txn(8'd3, 8'd5, 1'b0, 0, 0, 0);
      for (int k = 0; k < 40; k++)
         do_txn(N'($urandom), N'($urandom), 1'($urandom), int'($urandom_range(0, 12)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      repeat (3) @(negedge clock);
      chk("scoreboard_empty", longint'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
